// File: rtl/mult_chk_pkg.sv
// Shared types and helpers for the shift-add multiplier transaction checker.
// Provides the checker state enum, default parameter values and a
// saturating-increment helper used by all counters.
package mult_chk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } chk_state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_COV_BITS = 4;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_TIMEOUT  = 4 * DEF_WIDTH + 8;

    // Counters up to 32 bits wide are widened to 32 bits, bumped unless
    // already at max_val, and narrowed back by the caller.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/cov_bitmap.sv
// Operand-pair coverage bitmap.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   clear_i          synchronous clear of bitmap and count (wins over set_i)
//   set_i, idx_i     mark bit idx_i as covered
//   count_o          number of distinct bits set (saturating)
//   full_o           every bit of the bitmap is set
module cov_bitmap
    import mult_chk_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             set_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);
    localparam int               NBITS    = 1 << IDX_W;
    localparam logic [31:0]      CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NBITS);

    logic [NBITS-1:0] r_map;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             w_new;
    logic [CNT_W-1:0] w_count_nxt;

    // Only a first hit on a bit counts towards coverage.
    assign w_new       = set_i & ~r_map[idx_i];
    assign w_count_nxt = w_new ? CNT_W'(sat_inc(32'(r_count), CNT_MAX)) : r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_map   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (clear_i) begin
            r_map   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (set_i) begin
                r_map[idx_i] <= 1'b1;
            end
            r_count <= w_count_nxt;
            // Compared against the next count so full_o never lags count_o.
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    assign count_o = r_count;
    assign full_o  = r_full;

endmodule

// File: rtl/mult_txn_checker.sv
// Passive transaction checker for the shift-add multiplier.
// Watches start/ready/done and the operand/product buses, reports
// BAD_PRODUCT and NOT_READY as one-cycle pulses with saturating counters,
// tracks operand-pair coverage, start-during-ADD/SHIFT covers and a
// per-transaction timeout.
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   clear_i                        sync clear of counters/bitmap/sticky flags
//   start_i, ready_i, done_i       multiplier handshake
//   multiplicand_i, multiplier_i   operands, product_i DUT result
//   in_add_i, in_shift_i           DUT internal phase indicators
//   bp_err_o, nr_err_o             error pulses; bp/nr_count_o their counts
//   cov_count_o, cov_full_o        operand-pair coverage
//   start_add_cov_o, start_shift_cov_o, timeout_o   sticky flags
//   busy_o                         a transaction is being tracked
//
// state | meaning
// IDLE  | no transaction in flight; waiting for an accepted start
// BUSY  | operands latched, waiting for done_i or the watchdog
module mult_txn_checker
    import mult_chk_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int COV_BITS = DEF_COV_BITS,
    parameter int TIMEOUT  = 4 * WIDTH + 8,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic               ready_i,
    input  logic               done_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    input  logic [2*WIDTH-1:0] product_i,
    input  logic               in_add_i,
    input  logic               in_shift_i,
    output logic               bp_err_o,
    output logic               nr_err_o,
    output logic [CNT_W-1:0]   bp_count_o,
    output logic [CNT_W-1:0]   nr_count_o,
    output logic [CNT_W-1:0]   cov_count_o,
    output logic               cov_full_o,
    output logic               start_add_cov_o,
    output logic               start_shift_cov_o,
    output logic               timeout_o,
    output logic               busy_o
);
    localparam int              TMR_W    = $clog2(TIMEOUT + 1);
    localparam int              IDX_W    = 2 * COV_BITS;
    localparam logic [31:0]     CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    chk_state_e         r_state, w_state_nxt;
    logic [2*WIDTH-1:0] r_expected, w_expected_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic               w_bp, w_nr, w_accept, w_add_cov, w_shift_cov, w_timeout;
    logic               r_bp_err, r_nr_err, r_add_cov, r_shift_cov, r_timeout;
    logic [CNT_W-1:0]   r_bp_cnt, r_nr_cnt;
    logic [IDX_W-1:0]   w_cov_idx;

    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_timer_nxt    = r_timer;
        w_bp           = 1'b0;
        w_nr           = 1'b0;
        w_accept       = 1'b0;
        w_add_cov      = 1'b0;
        w_shift_cov    = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            IDLE: begin
                w_bp = done_i;
                if (start_i) begin
                    w_accept = ready_i;
                    w_nr     = ~ready_i;
                end
            end
            BUSY: begin
                if (done_i) begin
                    w_bp        = (product_i != r_expected);
                    w_state_nxt = IDLE;
                    // A start alongside done is judged as if already idle.
                    if (start_i) begin
                        w_accept = ready_i;
                        w_nr     = ~ready_i;
                    end
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                    if (start_i) begin
                        w_nr        = 1'b1;
                        w_add_cov   = in_add_i;
                        w_shift_cov = in_shift_i;
                    end
                    // This is the TIMEOUT-th busy cycle without done.
                    if (r_timer == TMR_LAST) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_accept) begin
            w_state_nxt    = BUSY;
            w_expected_nxt = {{WIDTH{1'b0}}, multiplicand_i} * {{WIDTH{1'b0}}, multiplier_i};
            w_timer_nxt    = '0;
        end
    end

    // Transaction tracking is not affected by clear_i.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_expected <= '0;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_expected <= w_expected_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bp_err    <= 1'b0;
            r_nr_err    <= 1'b0;
            r_bp_cnt    <= '0;
            r_nr_cnt    <= '0;
            r_add_cov   <= 1'b0;
            r_shift_cov <= 1'b0;
            r_timeout   <= 1'b0;
        end else if (clear_i) begin
            r_bp_err    <= 1'b0;
            r_nr_err    <= 1'b0;
            r_bp_cnt    <= '0;
            r_nr_cnt    <= '0;
            r_add_cov   <= 1'b0;
            r_shift_cov <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_bp_err <= w_bp;
            r_nr_err <= w_nr;
            if (w_bp) begin
                r_bp_cnt <= CNT_W'(sat_inc(32'(r_bp_cnt), CNT_MAX));
            end
            if (w_nr) begin
                r_nr_cnt <= CNT_W'(sat_inc(32'(r_nr_cnt), CNT_MAX));
            end
            r_add_cov   <= r_add_cov | w_add_cov;
            r_shift_cov <= r_shift_cov | w_shift_cov;
            r_timeout   <= r_timeout | w_timeout;
        end
    end

    assign w_cov_idx = {multiplicand_i[COV_BITS-1:0], multiplier_i[COV_BITS-1:0]};

    cov_bitmap #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_cov_bitmap (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (clear_i),
        .set_i   (w_accept),
        .idx_i   (w_cov_idx),
        .count_o (cov_count_o),
        .full_o  (cov_full_o)
    );

    assign bp_err_o          = r_bp_err;
    assign nr_err_o          = r_nr_err;
    assign bp_count_o        = r_bp_cnt;
    assign nr_count_o        = r_nr_cnt;
    assign start_add_cov_o   = r_add_cov;
    assign start_shift_cov_o = r_shift_cov;
    assign timeout_o         = r_timeout;
    assign busy_o            = (r_state == BUSY);

endmodule

// File: tb/tb_mult_txn_checker.sv
module tb_mult_txn_checker;
    localparam int WIDTH    = 8;
    localparam int COV_BITS = 4;
    localparam int TIMEOUT  = 4 * WIDTH + 8;
    localparam int CNT_W    = 10;
    localparam int NPAIRS   = 1 << (2 * COV_BITS);
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               clear_i = 1'b0;
    logic               start_i = 1'b0;
    logic               ready_i = 1'b0;
    logic               done_i = 1'b0;
    logic [WIDTH-1:0]   multiplicand_i = '0;
    logic [WIDTH-1:0]   multiplier_i = '0;
    logic [2*WIDTH-1:0] product_i = '0;
    logic               in_add_i = 1'b0;
    logic               in_shift_i = 1'b0;
    logic               bp_err_o, nr_err_o, cov_full_o;
    logic               start_add_cov_o, start_shift_cov_o, timeout_o, busy_o;
    logic [CNT_W-1:0]   bp_count_o, nr_count_o, cov_count_o;

    mult_txn_checker #(
        .WIDTH    (WIDTH),
        .COV_BITS (COV_BITS),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .clear_i           (clear_i),
        .start_i           (start_i),
        .ready_i           (ready_i),
        .done_i            (done_i),
        .multiplicand_i    (multiplicand_i),
        .multiplier_i      (multiplier_i),
        .product_i         (product_i),
        .in_add_i          (in_add_i),
        .in_shift_i        (in_shift_i),
        .bp_err_o          (bp_err_o),
        .nr_err_o          (nr_err_o),
        .bp_count_o        (bp_count_o),
        .nr_count_o        (nr_count_o),
        .cov_count_o       (cov_count_o),
        .cov_full_o        (cov_full_o),
        .start_add_cov_o   (start_add_cov_o),
        .start_shift_cov_o (start_shift_cov_o),
        .timeout_o         (timeout_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: transaction-level view of the checker.
    bit          m_busy;
    int unsigned m_exp;
    int          m_age;
    bit          m_seen [NPAIRS];
    int          m_cov, m_bp_cnt, m_nr_cnt;
    bit          m_bp, m_nr, m_add, m_shift, m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_exp = 0; m_age = 0;
        m_cov = 0; m_bp_cnt = 0; m_nr_cnt = 0;
        m_bp = 0; m_nr = 0; m_add = 0; m_shift = 0; m_to = 0;
        for (int i = 0; i < NPAIRS; i++) m_seen[i] = 0;
    endtask

    task automatic model_step();
        bit bp = 0, nr = 0, acc = 0, addc = 0, shc = 0, to = 0;
        int idx;
        if (!m_busy) begin
            bp = done_i;
            if (start_i) begin
                if (ready_i) acc = 1; else nr = 1;
            end
        end else if (done_i) begin
            bp = (32'(product_i) != m_exp);
            m_busy = 0;
            if (start_i) begin
                if (ready_i) acc = 1; else nr = 1;
            end
        end else begin
            m_age++;
            if (start_i) begin
                nr = 1; addc = in_add_i; shc = in_shift_i;
            end
            if (m_age == TIMEOUT) begin
                to = 1; m_busy = 0;
            end
        end
        if (acc) begin
            m_busy = 1;
            m_exp  = 32'(multiplicand_i) * 32'(multiplier_i);
            m_age  = 0;
        end
        if (clear_i) begin
            m_bp = 0; m_nr = 0; m_bp_cnt = 0; m_nr_cnt = 0; m_cov = 0;
            m_add = 0; m_shift = 0; m_to = 0;
            for (int i = 0; i < NPAIRS; i++) m_seen[i] = 0;
        end else begin
            m_bp = bp; m_nr = nr;
            if (bp && m_bp_cnt < CNT_MAX) m_bp_cnt++;
            if (nr && m_nr_cnt < CNT_MAX) m_nr_cnt++;
            m_add   = m_add | addc;
            m_shift = m_shift | shc;
            m_to    = m_to | to;
            if (acc) begin
                idx = (int'(multiplicand_i) % (1 << COV_BITS)) * (1 << COV_BITS)
                      + (int'(multiplier_i) % (1 << COV_BITS));
                if (!m_seen[idx]) begin
                    m_seen[idx] = 1;
                    if (m_cov < CNT_MAX) m_cov++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("bp_err", 32'(bp_err_o), 32'(m_bp));
        chk("nr_err", 32'(nr_err_o), 32'(m_nr));
        chk("bp_count", 32'(bp_count_o), 32'(m_bp_cnt));
        chk("nr_count", 32'(nr_count_o), 32'(m_nr_cnt));
        chk("cov_count", 32'(cov_count_o), 32'(m_cov));
        chk("cov_full", 32'(cov_full_o), 32'(m_cov == NPAIRS));
        chk("start_add_cov", 32'(start_add_cov_o), 32'(m_add));
        chk("start_shift_cov", 32'(start_shift_cov_o), 32'(m_shift));
        chk("timeout", 32'(timeout_o), 32'(m_to));
        chk("busy", 32'(busy_o), 32'(m_busy));
    endtask

    task automatic drive(input bit st, input bit rdy, input bit dn,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2*WIDTH-1:0] p,
                         input bit add = 0, input bit sh = 0, input bit clr = 0);
        start_i = st; ready_i = rdy; done_i = dn;
        multiplicand_i = a; multiplier_i = b; product_i = p;
        in_add_i = add; in_shift_i = sh; clear_i = clr;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 0, '0, '0, '0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;

        // reset state
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        #2 reset_n = 1'b1;
        idle(1);

        // 3 x 5 = 15, clean
        drive(1, 1, 0, 8'd3, 8'd5, '0);
        chk("t1_busy", 32'(busy_o), 32'd1);
        idle(4);
        drive(0, 1, 1, '0, '0, 16'd15);
        chk("t1_bp_err", 32'(bp_err_o), 32'd0);
        chk("t1_bp_count", 32'(bp_count_o), 32'd0);
        chk("t1_cov_count", 32'(cov_count_o), 32'd1);

        // 200 x 200, good then bad product
        drive(1, 1, 0, 8'd200, 8'd200, '0);
        idle(3);
        drive(0, 1, 1, '0, '0, 16'h9C40);
        chk("t2_clean", 32'(bp_err_o), 32'd0);
        drive(1, 1, 0, 8'd200, 8'd200, '0);
        idle(3);
        drive(0, 1, 1, '0, '0, 16'h9C41);
        chk("t2_bp_pulse", 32'(bp_err_o), 32'd1);
        chk("t2_bp_count", 32'(bp_count_o), 32'd1);
        idle(1);
        chk("t2_bp_pulse_end", 32'(bp_err_o), 32'd0);

        // NOT_READY in IDLE and mid-BUSY
        drive(1, 0, 0, 8'd1, 8'd2, '0);
        chk("t3_nr_pulse", 32'(nr_err_o), 32'd1);
        chk("t3_nr_count", 32'(nr_count_o), 32'd1);
        drive(1, 1, 0, 8'd7, 8'd9, '0);
        idle(2);
        drive(1, 1, 0, 8'd99, 8'd99, '0, 0, 1);
        chk("t3_nr_count2", 32'(nr_count_o), 32'd2);
        chk("t3_shift_cov", 32'(start_shift_cov_o), 32'd1);
        idle(1);
        drive(0, 1, 1, '0, '0, 16'd63);
        chk("t3_orig_checked", 32'(bp_err_o), 32'd0);

        // watchdog
        drive(1, 1, 0, 8'd1, 8'd1, '0);
        idle(TIMEOUT - 1);
        chk("t4_busy_before", 32'(busy_o), 32'd1);
        idle(1);
        chk("t4_timeout", 32'(timeout_o), 32'd1);
        chk("t4_not_busy", 32'(busy_o), 32'd0);
        chk("t4_no_bp", 32'(bp_err_o), 32'd0);
        drive(0, 1, 1, '0, '0, '0);
        chk("t4_spurious_done", 32'(bp_err_o), 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit st, rdy, dn;
            logic [2*WIDTH-1:0] p;
            st  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            dn  = m_busy ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 49) == 0);
            p   = ($urandom_range(0, 3) != 0) ? (2*WIDTH)'(m_exp) : (2*WIDTH)'($urandom);
            drive(st, rdy, dn, WIDTH'($urandom), WIDTH'($urandom), p,
                  1'($urandom), 1'($urandom), ($urandom_range(0, 199) == 0));
        end
        idle(TIMEOUT + 1);

        // coverage sweep
        drive(0, 1, 0, '0, '0, '0, 0, 0, 1);
        chk("t6_cleared", 32'(cov_count_o), 32'd0);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ra = {4'($urandom), 4'(a)};
                rb = {4'($urandom), 4'(b)};
                drive(1, 1, 0, ra, rb, '0);
                drive(0, 1, 1, '0, '0, 16'(ra) * 16'(rb));
            end
        end
        drive(1, 1, 0, 8'h00, 8'h00, '0);
        drive(0, 1, 1, '0, '0, 16'd0);
        idle(1);
        chk("t6_cov_count", 32'(cov_count_o), 32'd256);
        chk("t6_cov_full", 32'(cov_full_o), 32'd1);

        // clear
        drive(1, 0, 1, '0, '0, '0);
        drive(0, 1, 0, '0, '0, '0, 0, 0, 1);
        chk("t7_bp_count", 32'(bp_count_o), 32'd0);
        chk("t7_nr_count", 32'(nr_count_o), 32'd0);
        chk("t7_cov_count", 32'(cov_count_o), 32'd0);
        chk("t7_cov_full", 32'(cov_full_o), 32'd0);

        // saturation, bp and nr together
        for (int i = 0; i < CNT_MAX + 5; i++) drive(1, 0, 1, '0, '0, '0);
        chk("t8_bp_sat", 32'(bp_count_o), 32'(CNT_MAX));
        chk("t8_nr_sat", 32'(nr_count_o), 32'(CNT_MAX));
        chk("t8_both_pulse", 32'(bp_err_o & nr_err_o), 32'd1);

        // asynchronous reset mid-BUSY
        drive(1, 1, 0, 8'd5, 8'd6, '0, 1, 0);
        idle(2);
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        chk("t9_busy", 32'(busy_o), 32'd0);
        chk("t9_nr_count", 32'(nr_count_o), 32'd0);
        check_all();
        #2 reset_n = 1'b1;
        drive(1, 1, 0, 8'd2, 8'd3, '0);
        idle(2);
        drive(0, 1, 1, '0, '0, 16'd6);
        chk("t9_after_clean", 32'(bp_count_o), 32'd0);
        chk("t9_after_cov", 32'(cov_count_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_txn_checker.md
Name: mult_txn_checker

Overview:
- Synthesizable, parametrised transaction checker for the shift-add multiplier DUT.
- Sits beside the DUT on the multiplier interface signals and observes them passively.
- Flags BAD_PRODUCT and NOT_READY protocol errors as one-cycle pulses and keeps saturating error counters.
- Tracks operand-pair coverage in a bitmap, records start-in-ADD/SHIFT covers, and runs a per-transaction timeout watchdog.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH.
- COV_BITS, 4, low operand bits used as coverage index; bitmap holds 2^(2*COV_BITS) bits.
- TIMEOUT, 4*WIDTH+8, maximum cycles from accepted start to done_i.
- CNT_W, 16, width of error and coverage counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of counters, bitmap and sticky flags.
- start_i  in  1  DUT start.
- ready_i  in  1  DUT ready.
- done_i  in  1  DUT done; product valid this cycle.
- multiplicand_i  in  WIDTH  operand A.
- multiplier_i  in  WIDTH  operand B.
- product_i  in  2*WIDTH  DUT product.
- in_add_i  in  1  DUT is in an ADD state.
- in_shift_i  in  1  DUT is in a SHIFT state.
- bp_err_o  out  1  BAD_PRODUCT pulse.
- nr_err_o  out  1  NOT_READY pulse.
- bp_count_o  out  CNT_W  BAD_PRODUCT count.
- nr_count_o  out  CNT_W  NOT_READY count.
- cov_count_o  out  CNT_W  distinct operand pairs covered.
- cov_full_o  out  1  all pairs covered.
- start_add_cov_o  out  1  sticky: start seen during ADD.
- start_shift_cov_o  out  1  sticky: start seen during SHIFT.
- timeout_o  out  1  sticky watchdog expiry.
- busy_o  out  1  checker is tracking a transaction.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; every output 0; bitmap cleared; expected-product register 0; timer 0.
- clear_i: same effect as reset on the next edge, except a transaction in flight keeps running. clear_i has priority over same-cycle increments.
- State IDLE:
  - start_i & ready_i: latch expected = A*B (unsigned, 2*WIDTH bits, no truncation). Set the bitmap bit at index {A[COV_BITS-1:0], B[COV_BITS-1:0]}. Timer := 0. Go to BUSY.
  - start_i & !ready_i: nr_err_o pulse; stay IDLE.
  - done_i in IDLE (spurious done): bp_err_o pulse.
- State BUSY:
  - Timer increments each cycle.
  - done_i: if product_i != expected, bp_err_o pulse. Go to IDLE. done_i and start_i in the same cycle: check first, then apply the IDLE start rule against ready_i in that same cycle.
  - start_i without done_i: nr_err_o pulse. If in_add_i, set start_add_cov_o; if in_shift_i, set start_shift_cov_o. The transaction continues with the originally latched operands.
  - Timer reaches TIMEOUT without done_i: set timeout_o; go to IDLE. No bp_err pulse.
- Pulses are registered: asserted for exactly one cycle, the cycle after the triggering edge. The matching counter updates on the same edge.
- Counters saturate at 2^CNT_W-1.
- cov_count_o increments only when a previously clear bitmap bit is set.
- cov_full_o = (cov_count_o == 2^(2*COV_BITS)), registered.
- busy_o = (state == BUSY).
- If bp and nr events occur in the same cycle, both pulse and both counters increment.
- Reset mid-transaction: abandons it; no error is reported.

Decomposition:
- Package mult_chk_pkg:
  - state enum {IDLE, BUSY}.
  - Saturating-increment function.
  - Default parameter constants.
- Sub-module cov_bitmap (params IDX_W, CNT_W):
  - Inputs: set_i, idx_i, clear_i.
  - Outputs: count_o, full_o.
  - Owns the bitmap and the new-bit detection.

Test Plan:
- Start with A=3, B=5, ready_i=1; DUT returns done with product 15 -> no pulses; bp_count=0; cov_count=1.
- Start with A=200, B=200 (WIDTH=8); DUT returns 0x9C40 -> clean. Same operands with product 0x9C41 -> bp_err_o pulses once; bp_count=1.
- start_i with ready_i=0 in IDLE -> nr_err_o pulse; nr_count=1. start_i mid-BUSY with in_shift_i=1 -> nr_count=2; start_shift_cov_o=1; original product still checked.
- Accepted start, no done for TIMEOUT cycles -> timeout_o=1; busy_o=0; no bp pulse. done_i afterwards in IDLE -> bp_err_o pulse.
- Sweep all 16x16 pairs of low nibbles (COV_BITS=4), repeating pair (0,0) -> cov_count=256; cov_full_o=1; repeat of (0,0) does not increment.
- Set counters to saturation, trigger another error -> counter holds at max. Assert reset_n low mid-BUSY -> all outputs 0 asynchronously. clear_i -> counters 0, cov_full_o=0.
